turn_controller: RTL and testbench

Sequencing FSM for the Connect-4 board datapath. It turns a player's "go" press into the datapath's load, validate and draw steps. It then issues one RAM write strobe per accepted move and alternates the active player. It also stops the game on a win or when the board is full. It sits between the user-input front end and the column datapath / board RAM; the column selection itself goes straight to the datapath.

---
 rtl/connect4_pkg.sv | 26 ++
 rtl/phase_timer.sv | 27 ++
 rtl/turn_controller.sv | 104 ++++++++++
 tb/tb_turn_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: player encodings, board size and the
// turn-controller state encoding.
package connect4_pkg;

    localparam int BOARD_CELLS = 64;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P1     = 2'b01;
    localparam logic [1:0] P2     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_DRAW   = 3'd3,
        S_WRITE  = 3'd4,
        S_NEXT   = 3'd5,
        S_REJECT = 3'd6,
        S_OVER   = 3'd7
    } ctrl_state_e;

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter; done is high while the count sits at 1, i.e. on the
// last cycle of a timed phase.
module phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/turn_controller.sv
// Connect-4 turn sequencer: turns a go press into load / check / draw / write
// steps, counts accepted moves, alternates players and ends the game.
module turn_controller
    import connect4_pkg::*;
#(
    parameter int DRAW_CYCLES   = 2,
    parameter int REJECT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        valid,
    input  logic        game_won,
    output logic        ld_column,
    output logic        draw,
    output logic        ram_we,
    output logic [1:0]  player,
    output logic        busy,
    output logic        invalid,
    output logic        game_over,
    output logic        board_full,
    output logic [1:0]  winner,
    output logic [6:0]  moves,
    output ctrl_state_e dbg_state
);

    // Handshake: go is a level; only a 0->1 seen in IDLE starts a move. The
    // datapath answers with valid during CHECK (one cycle after ld_column),
    // and game_won is only looked at in NEXT; no other cycle consumes them.

    localparam int MAX_CYC = (DRAW_CYCLES > REJECT_CYCLES) ? DRAW_CYCLES : REJECT_CYCLES;
    localparam int TIMER_W = $clog2(MAX_CYC + 1);
    localparam logic [6:0] FULL_COUNT = 7'(BOARD_CELLS);

    ctrl_state_e        state, state_next;
    logic               prev_go;
    logic               go_rise;
    logic [6:0]         moves_inc;
    logic               timer_load;
    logic               timer_done;
    logic [TIMER_W-1:0] timer_value;

    assign go_rise     = go & ~prev_go;
    assign moves_inc   = (moves == FULL_COUNT) ? moves : moves + 7'd1;
    assign timer_load  = (state == S_CHECK);
    assign timer_value = valid ? TIMER_W'(DRAW_CYCLES) : TIMER_W'(REJECT_CYCLES);

    phase_timer #(.W(TIMER_W)) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // prev_go resets high so a button held through reset does not fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            prev_go    <= 1'b1;
            player     <= P1;
            moves      <= 7'd0;
            winner     <= P_NONE;
            board_full <= 1'b0;
        end else begin
            state   <= state_next;
            prev_go <= go;
            if (state == S_NEXT) begin
                moves <= moves_inc;
                if (game_won) begin
                    winner <= player;
                end else if (moves_inc == FULL_COUNT) begin
                    board_full <= 1'b1;
                end else begin
                    player <= other_player(player);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (go_rise) state_next = S_LOAD;
            S_LOAD:   state_next = S_CHECK;
            S_CHECK:  state_next = valid ? S_DRAW : S_REJECT;
            S_DRAW:   if (timer_done) state_next = S_WRITE;
            S_WRITE:  state_next = S_NEXT;
            S_NEXT:   state_next = (game_won || moves_inc == FULL_COUNT) ? S_OVER : S_IDLE;
            S_REJECT: if (timer_done) state_next = S_IDLE;
            S_OVER:   state_next = S_OVER;
            default:  state_next = S_IDLE;
        endcase
    end

    assign ld_column = (state == S_LOAD);
    assign draw      = (state == S_DRAW);
    assign ram_we    = (state == S_WRITE);
    assign invalid   = (state == S_REJECT);
    assign game_over = (state == S_OVER);
    assign busy      = (state != S_IDLE) && (state != S_OVER);
    assign dbg_state = state;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: per-cycle expected state/strobe traces
// plus player, move-count and end-of-game flag checks.
module tb_turn_controller;
    import connect4_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        valid = 1'b0;
    logic        game_won = 1'b0;
    logic        ld_column, draw, ram_we, busy, invalid, game_over, board_full;
    logic [1:0]  player, winner;
    logic [6:0]  moves;
    ctrl_state_e dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] exp_q[$];
    logic [1:0] exp_player;
    logic [6:0] exp_moves;
    logic [1:0] exp_winner;

    turn_controller dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .valid      (valid),
        .game_won   (game_won),
        .ld_column  (ld_column),
        .draw       (draw),
        .ram_we     (ram_we),
        .player     (player),
        .busy       (busy),
        .invalid    (invalid),
        .game_over  (game_over),
        .board_full (board_full),
        .winner     (winner),
        .moves      (moves),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // trace entry: {state, ld_column, draw, ram_we, invalid}
    function automatic logic [6:0] ent(input ctrl_state_e s, input logic [3:0] f);
        return {s, f};
    endfunction

    function automatic logic [6:0] observed();
        return {dbg_state, ld_column, draw, ram_we, invalid};
    endfunction

    task automatic model_reset();
        exp_player = P1;
        exp_moves  = 7'd0;
        exp_winner = P_NONE;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        go = 1'b0;
        valid = 1'b0;
        game_won = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    // One move, go raised just after the current edge (E0 is the next edge).
    // mode 0: go dropped after E0; 1: go held; 2: go dropped, re-raised in DRAW.
    task automatic do_move(input logic v, input logic won, input int mode);
        logic full;
        int   n;
        full = v && !won && (exp_moves + 7'd1 == 7'(BOARD_CELLS));
        go = 1'b1;
        valid = v;
        game_won = won;
        exp_q.push_back(ent(S_LOAD, 4'b1000));
        exp_q.push_back(ent(S_CHECK, 4'b0000));
        if (v) begin
            exp_q.push_back(ent(S_DRAW, 4'b0100));
            exp_q.push_back(ent(S_DRAW, 4'b0100));
            exp_q.push_back(ent(S_WRITE, 4'b0010));
            exp_q.push_back(ent(S_NEXT, 4'b0000));
            exp_q.push_back((won || full) ? ent(S_OVER, 4'b0000) : ent(S_IDLE, 4'b0000));
        end else begin
            for (int k = 0; k < 4; k++) exp_q.push_back(ent(S_REJECT, 4'b0001));
            exp_q.push_back(ent(S_IDLE, 4'b0000));
        end
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0 && mode != 1) go = 1'b0;
            if (i == 2 && mode == 2) go = 1'b1;
            check($sformatf("trace[%0d]", i), 32'(observed()), 32'(exp_q.pop_front()));
        end
        game_won = 1'b0;
        if (v) begin
            exp_moves = exp_moves + 7'd1;
            if (won) exp_winner = exp_player;
            else if (!full) exp_player = other_player(exp_player);
        end
        check("player", 32'(player), 32'(exp_player));
        check("moves", 32'(moves), 32'(exp_moves));
        check("winner", 32'(winner), 32'(exp_winner));
    endtask

    initial begin
        model_reset();
        apply_reset();
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        check("rst_player", 32'(player), 32'(P1));
        check("rst_moves", 32'(moves), 32'd0);
        check("rst_winner", 32'(winner), 32'd0);
        check("rst_flags", 32'({ld_column, draw, ram_we, invalid, busy, game_over, board_full}), 32'd0);

        // go held through reset must not start a move
        reset = 1'b1;
        go = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("held_thru_reset", 32'(dbg_state), 32'(S_IDLE));
        go = 1'b0;
        tick();

        // move 1: accepted, P1 -> P2; IDLE on the 7th edge after go is driven
        do_move(1'b1, 1'b0, 0);
        check("busy_idle", 32'(busy), 32'd0);

        // rejected column: player and moves untouched
        do_move(1'b0, 1'b0, 0);

        // move 2: go held for 20 cycles in total yields a single move
        do_move(1'b1, 1'b0, 1);
        for (int i = 0; i < 13; i++) begin
            tick();
            check("held_idle", 32'(observed()), 32'(ent(S_IDLE, 4'b0000)));
        end
        go = 1'b0;
        tick();

        // move 3: a go edge during DRAW is dropped, not queued
        do_move(1'b1, 1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("toggle_idle", 32'(observed()), 32'(ent(S_IDLE, 4'b0000)));
        end
        go = 1'b0;
        tick();

        // moves 4..6, then move 7 by P1 wins
        for (int i = 0; i < 3; i++) do_move(1'b1, 1'b0, 0);
        do_move(1'b1, 1'b1, 0);
        check("win_over", 32'(game_over), 32'd1);
        check("win_winner", 32'(winner), 32'(P1));
        check("win_full", 32'(board_full), 32'd0);
        check("win_moves", 32'(moves), 32'd7);
        for (int i = 0; i < 3; i++) begin
            go = 1'b1;
            tick();
            check("over_go_hi", 32'({observed(), busy}), 32'({ent(S_OVER, 4'b0000), 1'b0}));
            go = 1'b0;
            tick();
            check("over_go_lo", 32'({observed(), busy}), 32'({ent(S_OVER, 4'b0000), 1'b0}));
        end
        check("over_player", 32'(player), 32'(P1));

        // fill the board
        apply_reset();
        for (int i = 0; i < BOARD_CELLS; i++) do_move(1'b1, 1'b0, 0);
        check("full_flag", 32'(board_full), 32'd1);
        check("full_over", 32'(game_over), 32'd1);
        check("full_moves", 32'(moves), 32'd64);
        check("full_winner", 32'(winner), 32'd0);
        go = 1'b1;
        tick();
        check("full_go", 32'(observed()), 32'(ent(S_OVER, 4'b0000)));
        go = 1'b0;

        // reset during the second draw cycle
        apply_reset();
        do_move(1'b1, 1'b0, 0);
        go = 1'b1;
        valid = 1'b1;
        tick();
        go = 1'b0;
        tick();
        tick();
        tick();
        check("mid_draw", 32'(observed()), 32'(ent(S_DRAW, 4'b0100)));
        reset = 1'b1;
        tick();
        check("rst_draw_state", 32'(observed()), 32'(ent(S_IDLE, 4'b0000)));
        check("rst_draw_we", 32'({ram_we, busy}), 32'd0);
        check("rst_draw_player", 32'(player), 32'(P1));
        check("rst_draw_moves", 32'(moves), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
